// File: rtl/alu_seq_pkg.sv
// Shared op encodings and FSM state type for alu_seq.
// ALU_SEQ_MULDIV_EN adds the ITER state used by the iterative MUL/DIV unit.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;

`ifdef ALU_SEQ_MULDIV_EN
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

endpackage

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle unsigned shift-add multiplier / restoring divider.
// done is raised during the final step; res carries that step's outcome combinationally.
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             abort,
  input  logic             start,
  input  logic             div,
  input  logic             hi,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]   opb;
  logic [CW-1:0]      cnt;
  logic               busy, div_q, hi_q;
  logic [WIDTH:0]     sum, shl, rem_n;
  logic               ge;

  // acc = {hi, lo} for MUL (lo = remaining multiplier bits), {rem, quo} for DIV
  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    shl     = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ge      = shl >= {1'b0, opb};
    rem_n   = ge ? (shl - {1'b0, opb}) : shl;
    acc_nxt = div_q ? {rem_n[WIDTH-1:0], acc[WIDTH-2:0], ge}
                    : {sum, acc[WIDTH-1:1]};
  end

  assign done = busy & (cnt == CW'(WIDTH-1));
  assign res  = hi_q ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (abort) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      acc   <= {WIDTH'(0), a};
      opb   <= b;
      div_q <= div;
      hi_q  <= hi;
    end else if (busy) begin
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered valid/ready ALU: 8 base ops in one cycle, result held until taken.
// Define ALU_SEQ_MULDIV_EN for iterative MUL/DIV; otherwise every op[3]=1 is illegal.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             alt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic             err
);

  state_t           state_q, state_d;
  logic             accept, load_base, md_fin;
  logic [WIDTH-1:0] b_eff, sum, base_res, md_res, ld_res;
  logic [SHW-1:0]   shamt;
  logic             base_v, base_err;

  assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept   = in_valid & in_ready;
  assign shamt    = b[SHW-1:0];

  always_comb begin
    b_eff    = alt ? (~b + 1'b1) : b;
    sum      = a + b_eff;
    base_res = '0;
    base_v   = 1'b0;
    base_err = 1'b0;
    case (op)
      OP_ADD: begin
        base_res = sum;
        base_v   = (a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLL:  base_res = a << shamt;
      OP_SLT:  base_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: base_res = {{(WIDTH-1){1'b0}}, a < b};
      OP_XOR:  base_res = a ^ b;
      OP_SRL:  base_res = alt ? WIDTH'($signed(a) >>> shamt) : (a >> shamt);
      OP_OR:   base_res = a | b;
      OP_AND:  base_res = a & b;
      default: base_err = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_MULDIV_EN
  logic muldiv, start_md, md_done;

  assign muldiv = (op == OP_MUL) | (op == OP_DIV);
  assign md_fin = (state_q == ITER) & md_done;

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_md (
    .clk   (clk),
    .abort (~rst_n),
    .start (start_md),
    .div   (op[0]),
    .hi    (alt),
    .a     (a),
    .b     (b),
    .done  (md_done),
    .res   (md_res)
  );
`else
  assign md_fin = 1'b0;
  assign md_res = '0;
`endif

  always_comb begin
    state_d   = state_q;
    load_base = 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
    start_md  = 1'b0;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
`ifdef ALU_SEQ_MULDIV_EN
          if (muldiv) begin
            start_md = 1'b1;
            state_d  = ITER;
          end else
`endif
          begin
            load_base = 1'b1;
            state_d   = DONE;
          end
        end else if ((state_q == DONE) & out_ready) begin
          state_d = IDLE;
        end
      end
`ifdef ALU_SEQ_MULDIV_EN
      ITER: if (md_done) state_d = DONE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign ld_res = load_base ? base_res : md_res;

  // A DONE-state accept replaces the held result in the same edge it is taken
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_v    <= 1'b0;
      err       <= 1'b0;
    end else if (load_base | md_fin) begin
      out_valid <= 1'b1;
      result    <= ld_res;
      flag_z    <= (ld_res == '0);
      flag_n    <= ld_res[WIDTH-1];
      flag_v    <= load_base & base_v;
      err       <= load_base & base_err;
    end else if (out_valid & out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed scoreboard bench for alu_seq (WIDTH=32); honours ALU_SEQ_MULDIV_EN.
module tb_alu_seq;

  localparam int W = 32;
`ifdef ALU_SEQ_MULDIV_EN
  localparam int MDLAT = 33;
`else
  localparam int MDLAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, alt, out_valid, out_ready;
  logic         flag_z, flag_n, flag_v, err;
  logic [W-1:0] a, b, result;
  logic [3:0]   op;

  typedef struct {
    string        tag;
    logic [W-1:0] res;
    logic         z, n, v, e;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   waits;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .alt(alt), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] o, input logic al,
                                 input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t         e;
    logic [W-1:0] be;
    logic [63:0]  p;
    e.tag = ""; e.res = '0; e.v = 1'b0; e.e = 1'b0;
    case (o)
      4'b0000: begin
        be    = al ? (~y + 1) : y;
        e.res = x + be;
        e.v   = (x[W-1] == be[W-1]) && (e.res[W-1] != x[W-1]);
      end
      4'b0001: e.res = x << y[4:0];
      4'b0010: e.res = ($signed(x) < $signed(y)) ? 1 : 0;
      4'b0011: e.res = (x < y) ? 1 : 0;
      4'b0100: e.res = x ^ y;
      4'b0101: e.res = al ? $unsigned($signed(x) >>> y[4:0]) : (x >> y[4:0]);
      4'b0110: e.res = x | y;
      4'b0111: e.res = x & y;
`ifdef ALU_SEQ_MULDIV_EN
      4'b1000: begin
        p     = {32'd0, x} * {32'd0, y};
        e.res = al ? p[63:32] : p[31:0];
      end
      4'b1001: begin
        if (y == 0) e.res = al ? x : '1;
        else        e.res = al ? (x % y) : (x / y);
      end
`endif
      default: e.e = 1'b1;
    endcase
    e.z = (e.res == 0);
    e.n = e.res[W-1];
    return e;
  endfunction

  // Scoreboard: a result is consumed at the edge following a negedge with valid & ready
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_output", out_valid, 0);
      else begin
        m = q.pop_front();
        chk({m.tag, "_res"}, result, m.res);
        chk({m.tag, "_z"},   flag_z, m.z);
        chk({m.tag, "_n"},   flag_n, m.n);
        chk({m.tag, "_v"},   flag_v, m.v);
        chk({m.tag, "_err"}, err,    m.e);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge (+latency wait)
  task automatic issue(input string tag, input logic [3:0] o, input logic al,
                       input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit push, input int lat, output int nw);
    exp_t e;
    int   c;
    op = o; alt = al; a = x; b = y; in_valid = 1'b1;
    nw = 0;
    @(negedge clk);
    while (!in_ready && nw < 100) begin
      @(negedge clk);
      nw++;
    end
    if (nw >= 100) chk({tag, "_accept_timeout"}, in_ready, 1);
    if (push) begin
      e = model(o, al, x, y);
      e.tag = tag;
      q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (lat > 0) begin
      c = 1;
      while (!out_valid && c < 100) begin
        @(posedge clk); #1;
        c++;
      end
      chk({tag, "_lat"}, c, lat);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; alt = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result",    result,    0);
    chk("rst_z",         flag_z,    0);
    chk("rst_n",         flag_n,    0);
    chk("rst_v",         flag_v,    0);
    chk("rst_err",       err,       0);
    chk("rst_in_ready",  in_ready,  1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue("add_ovf",  4'b0000, 0, 32'h7FFFFFFF, 32'h1,        1, 1, waits);
    issue("sub_neg",  4'b0000, 1, 32'd5,        32'd7,        1, 1, waits);
    issue("sub_ovf",  4'b0000, 1, 32'h80000000, 32'h1,        1, 1, waits);
    issue("sra",      4'b0101, 1, 32'h80000000, 32'h24,       1, 1, waits);
    issue("srl",      4'b0101, 0, 32'h80000000, 32'h24,       1, 1, waits);
    issue("sll",      4'b0001, 0, 32'h1,        32'd31,       1, 1, waits);
    issue("slt",      4'b0010, 0, 32'hFFFFFFFF, 32'h1,        1, 1, waits);
    issue("sltu",     4'b0011, 0, 32'hFFFFFFFF, 32'h1,        1, 1, waits);
    issue("or",       4'b0110, 0, 32'hF0F00000, 32'h0000F0F0, 1, 1, waits);
    issue("and_zero", 4'b0111, 0, 32'hF0F0F0F0, 32'h0F0F0F0F, 1, 1, waits);
    issue("mul_lo",   4'b1000, 0, 32'hFFFF,     32'hFFFF,     1, MDLAT, waits);
    issue("mul_hi",   4'b1000, 1, 32'hFFFF,     32'hFFFF,     1, MDLAT, waits);
    issue("mul_big",  4'b1000, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, MDLAT, waits);
    issue("div_q",    4'b1001, 0, 32'd100,      32'd7,        1, MDLAT, waits);
    issue("div_r",    4'b1001, 1, 32'd100,      32'd7,        1, MDLAT, waits);
    issue("div0_q",   4'b1001, 0, 32'd5,        32'd0,        1, MDLAT, waits);
    issue("div0_r",   4'b1001, 1, 32'd5,        32'd0,        1, MDLAT, waits);
    issue("illegal",  4'b1011, 0, 32'h1234,     32'h5678,     1, 1, waits);
    repeat (2) @(posedge clk); #1;

    // Backpressure: held result must stay frozen and block new requests
    out_ready = 1'b0;
    issue("xor_hold", 4'b0100, 0, 32'hA5A5A5A5, 32'h5A5A5A5A, 1, 1, waits);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_res",   result,    32'hFFFFFFFF);
      chk("hold_n",     flag_n,    1);
      chk("hold_z",     flag_z,    0);
      chk("hold_ready", in_ready,  0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue("b2b_and", 4'b0111, 0, 32'h00FF00FF, 32'h0F0F0F0F, 1, 1, waits);
    chk("b2b_nowait", waits, 0);
    repeat (2) @(posedge clk); #1;

    // Reset while a result is held
    out_ready = 1'b0;
    issue("xor_drop", 4'b0100, 0, 32'h1, 32'h3, 0, 1, waits);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_hold_valid", out_valid, 0);
    chk("rst_hold_res",   result,    0);
    chk("rst_hold_ready", in_ready,  1);
    out_ready = 1'b1;

`ifdef ALU_SEQ_MULDIV_EN
    // Reset mid-division: the aborted op must never produce a result
    issue("div_abort", 4'b1001, 0, 32'd100, 32'd7, 0, 0, waits);
    repeat (10) @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_valid", out_valid, 0);
    chk("abort_ready", in_ready,  1);
    repeat (40) @(posedge clk); #1;
    chk("abort_quiet", out_valid, 0);
`endif

    issue("add_post", 4'b0000, 0, 32'd3, 32'd4, 1, 1, waits);
    repeat (3) @(posedge clk); #1;
    chk("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
